// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding,
// default sizes and a constant-friendly ceil(log2) helper.
package fifo_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 16;

    typedef enum logic {
        IDLE  = ST_IDLE,
        BURST = ST_BURST
    } arb_state_t;

    // Number of bits needed to hold values 0..value-1 (0 for value<=1).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side bus of the FIFO write arbiter: requests and words in,
// per-requester acks and the muxed FIFO write port out.
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    localparam int ID_W = clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic                    fifo_full;
    logic [DATA_W-1:0]       fifo_data;
    logic                    fifo_wr_en;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;

    modport master (
        output req, req_data, fifo_full,
        input  ack, fifo_data, fifo_wr_en, grant_id, busy
    );

    modport slave (
        input  req, req_data, fifo_full,
        output ack, fifo_data, fifo_wr_en, grant_id, busy
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin find-first-set: returns the first asserted
// request found scanning upward from 'start' with wrap-around.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic             valid,
    output logic [ID_W-1:0]  winner
);

    // Walk all N_REQ positions starting at 'start'; first hit wins.
    always_comb begin : scan
        int idx;
        logic [ID_W-1:0] cand;
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx  = (int'(start) + i) % N_REQ;
            cand = idx[ID_W-1:0];
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing the single FIFO write port between
// N_REQ producers. Writes are combinational against the live full flag,
// so the FIFO can never be written while full.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input logic                 clk_1,
    input logic                 rst,
    fifo_write_arbiter_if.slave bus
);

    localparam int ID_W  = clog2(N_REQ);
    localparam int CNT_W = clog2(MAX_BURST + 1);

    arb_state_t        state, state_nxt;
    logic [ID_W-1:0]   owner, owner_nxt;
    logic [CNT_W-1:0]  burst_cnt, cnt_nxt;
    logic [ID_W-1:0]   pick_start;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_winner;
    logic [N_REQ-1:0]  ack_c;
    logic              wr_c;
    logic [DATA_W-1:0] data_c;
    logic [DATA_W-1:0] words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_split
        assign words[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    // Priority starts just after the last owner, so reset owner N_REQ-1
    // gives requester 0 first pick.
    assign pick_start = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req    (bus.req),
        .start  (pick_start),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // State, owner and burst counter registers with synchronous reset.
    always_ff @(posedge clk_1) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= ID_W'(N_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    // Arbitrate in IDLE, stream the owner's words in BURST; outputs are gated off during reset.
    always_comb begin
        logic take;
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = burst_cnt;
        ack_c     = '0;
        wr_c      = 1'b0;
        data_c    = '0;
        take      = bus.req[owner] && !bus.fifo_full;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_nxt = pick_winner;
                    cnt_nxt   = '0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (take) begin
                    ack_c[owner] = 1'b1;
                    wr_c         = 1'b1;
                    data_c       = words[owner];
                    if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = burst_cnt + 1'b1;
                    end
                end else if (!bus.req[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst) begin
            ack_c  = '0;
            wr_c   = 1'b0;
            data_c = '0;
        end
    end

    assign bus.ack        = ack_c;
    assign bus.fifo_wr_en = wr_c;
    assign bus.fifo_data  = data_c;
    assign bus.grant_id   = owner;
    assign bus.busy       = (state == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: a behavioural arbiter model
// predicts every cycle's outputs, a separate monitor compares them.
module tb_fifo_write_arbiter;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 4;
    localparam int ID_W      = 2;

    typedef struct {
        logic [N_REQ-1:0]  ack;
        logic              wr;
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   grant;
        logic              busy;
    } exp_t;

    logic clk_1;
    logic rst;

    fifo_write_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    fifo_write_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_1 (clk_1),
        .rst   (rst),
        .bus   (bus.slave)
    );

    exp_t              exp_q [$];
    logic [DATA_W-1:0] src_q [N_REQ][$];
    logic              rst_q [$];
    logic              full_q [$];
    bit                random_full;

    bit m_busy;
    int m_owner;
    int m_taken;

    int checks;
    int errors;
    int dut_writes;
    int exp_writes;

    // Free-running write clock.
    initial begin
        clk_1 = 1'b0;
        forever #5 clk_1 = ~clk_1;
    end

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_output(input exp_t e);
        check_field("ack", 32'(bus.ack), 32'(e.ack));
        check_field("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(e.wr));
        check_field("fifo_data", 32'(bus.fifo_data), 32'(e.data));
        check_field("grant_id", 32'(bus.grant_id), 32'(e.grant));
        check_field("busy", 32'(bus.busy), 32'(e.busy));
    endtask

    // Monitor: pop the prediction for this cycle and compare away from the active edge.
    always @(negedge clk_1) begin
        exp_t e;
        if (bus.fifo_wr_en === 1'b1) dut_writes = dut_writes + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e);
        end
    end

    // One cycle: drive requesters from their word queues, predict outputs, advance model.
    task automatic apply_stimulus();
        exp_t                    e;
        logic [N_REQ-1:0]        r;
        logic [N_REQ*DATA_W-1:0] rd;
        logic                    f;
        logic                    rs;
        int                      j;
        bit                      take;
        rs = (rst_q.size() > 0) ? rst_q.pop_front() : 1'b1;
        if (full_q.size() > 0) f = full_q.pop_front();
        else f = random_full ? ($urandom_range(3) == 0) : 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            r[i] = (src_q[i].size() > 0);
            rd[i*DATA_W +: DATA_W] = r[i] ? src_q[i][0] : DATA_W'($urandom);
        end
        rst           = rs;
        bus.req       = r;
        bus.req_data  = rd;
        bus.fifo_full = f;

        e.ack   = '0;
        e.wr    = 1'b0;
        e.data  = '0;
        e.grant = ID_W'(m_owner);
        e.busy  = m_busy;
        if (!rs) begin
            m_busy  = 1'b0;
            m_owner = N_REQ - 1;
            m_taken = 0;
        end else if (!m_busy) begin
            if (r != '0) begin
                for (int d = 1; d <= N_REQ; d++) begin
                    j = (m_owner + d) % N_REQ;
                    if (r[j]) begin
                        m_owner = j;
                        break;
                    end
                end
                m_busy  = 1'b1;
                m_taken = 0;
            end
        end else begin
            take = r[m_owner] && !f;
            if (take) begin
                e.ack[m_owner] = 1'b1;
                e.wr           = 1'b1;
                e.data         = src_q[m_owner].pop_front();
                exp_writes     = exp_writes + 1;
                m_taken        = m_taken + 1;
                if (m_taken == MAX_BURST) m_busy = 1'b0;
            end else if (!r[m_owner]) begin
                m_busy = 1'b0;
            end
        end
        exp_q.push_back(e);
        @(posedge clk_1);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) apply_stimulus();
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < N_REQ; i++) s = s + src_q[i].size();
        return s;
    endfunction

    // Directed scenarios followed by a randomized soak and a bounded drain.
    initial begin
        checks        = 0;
        errors        = 0;
        dut_writes    = 0;
        exp_writes    = 0;
        random_full   = 1'b0;
        rst           = 1'b0;
        bus.req       = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        repeat (2) @(posedge clk_1);
        #1;
        m_busy  = 1'b0;
        m_owner = N_REQ - 1;
        m_taken = 0;
        dut_writes = 0;

        $display("[TB] reset state");
        rst_q.push_back(1'b0);
        run_cycles(1);

        $display("[TB] single requester burst cap");
        for (int k = 0; k < 6; k++) src_q[0].push_back(DATA_W'(16'hA000 + k));
        run_cycles(14);

        $display("[TB] round robin all requesters");
        rst_q.push_back(1'b0);
        for (int i = 0; i < N_REQ; i++)
            for (int k = 0; k < 5; k++) src_q[i].push_back(DATA_W'(16'hB000 + i*16 + k));
        run_cycles(32);

        $display("[TB] full stall mid burst");
        rst_q.push_back(1'b0);
        for (int k = 0; k < 4; k++) src_q[2].push_back(DATA_W'(16'hC000 + k));
        full_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        run_cycles(12);

        $display("[TB] early release");
        rst_q.push_back(1'b0);
        for (int k = 0; k < 2; k++) src_q[1].push_back(DATA_W'(16'hD100 + k));
        for (int k = 0; k < 4; k++) src_q[3].push_back(DATA_W'(16'hD300 + k));
        run_cycles(14);

        $display("[TB] reset mid burst");
        rst_q.push_back(1'b0);
        for (int k = 0; k < 4; k++) src_q[3].push_back(DATA_W'(16'hE300 + k));
        run_cycles(4);
        for (int k = 0; k < 2; k++) src_q[1].push_back(DATA_W'(16'hE100 + k));
        rst_q.push_back(1'b0);
        run_cycles(14);

        $display("[TB] randomized traffic");
        random_full = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            int who;
            who = $urandom_range(N_REQ - 1);
            if ($urandom_range(2) != 0 && src_q[who].size() < 4)
                src_q[who].push_back(DATA_W'($urandom));
            rst_q.push_back(($urandom_range(127) == 0) ? 1'b0 : 1'b1);
            apply_stimulus();
        end

        random_full = 1'b0;
        for (int c = 0; c < 400 && pending() > 0; c++) apply_stimulus();
        check_field("drain_pending", 32'(pending()), 32'd0);
        run_cycles(3);
        @(negedge clk_1);
        #1;
        check_field("write_count", 32'(dut_writes), 32'(exp_writes));
        check_field("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
